// File: rtl/encoder8_3_seq.sv
// Registered 8-to-3 one-hot encoder with a one-entry valid/ready output stage.
// Flags zero-hot and multi-hot inputs and keeps a saturating error count.
module encoder8_3_seq #(
    parameter int PRIORITY_MSB = 1,
    parameter int ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_code,
    output logic             out_zero,
    output logic             out_multi,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
);

    // state    | meaning
    // ST_EMPTY | output register holds nothing; out_valid=0
    // ST_FULL  | output register holds a result; out_valid=1
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_code;
    logic             r_zero;
    logic             r_multi;
    logic [ERR_W-1:0] r_err;

    logic             w_accept;
    logic             w_load;
    logic [3:0]       w_ones;
    logic [2:0]       w_idx;
    logic             w_zero;
    logic             w_multi;
    logic             w_bad;
    logic [ERR_W-1:0] w_err_base;
    logic [ERR_W-1:0] w_err_nxt;

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    assign out_code  = r_code;
    assign out_zero  = r_zero;
    assign out_multi = r_multi;
    assign err_cnt   = r_err;

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_ones = w_ones + {3'd0, in_data[i]};
        end
    end

    // Scan order decides which set bit survives: the last match wins.
    always_comb begin
        w_idx = 3'd0;
        if (PRIORITY_MSB != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (in_data[i]) begin
                    w_idx = 3'(i);
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (in_data[i]) begin
                    w_idx = 3'(i);
                end
            end
        end
    end

    assign w_zero  = (w_ones == 4'd0);
    assign w_multi = (w_ones > 4'd1);
    assign w_bad   = w_zero || w_multi;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load      = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Clear takes effect before the increment so a same-cycle error counts as 1.
    always_comb begin
        w_err_base = err_clr ? '0 : r_err;
        w_err_nxt  = w_err_base;
        if (w_accept && w_bad && (w_err_base != {ERR_W{1'b1}})) begin
            w_err_nxt = w_err_base + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_code  <= 3'd0;
            r_zero  <= 1'b0;
            r_multi <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_code  <= w_zero ? 3'd0 : w_idx;
                r_zero  <= w_zero;
                r_multi <= w_multi;
            end
        end
    end

endmodule

// File: tb/tb_encoder8_3_seq.sv
// Scoreboard bench for encoder8_3_seq: three instances (MSB priority, LSB priority,
// 2-bit error counter) share one stimulus stream and are checked against a reference model.
module tb_encoder8_3_seq;

    typedef struct packed {
        logic [2:0] code;
        logic       zero;
        logic       multi;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       err_clr;

    logic       rdy_m, rdy_l, rdy_s;
    logic       vld_m, vld_l, vld_s;
    logic [2:0] code_m, code_l, code_s;
    logic       zero_m, zero_l, zero_s;
    logic       multi_m, multi_l, multi_s;
    logic [7:0] err_m, err_l;
    logic [1:0] err_s;

    int errors = 0;
    int checks = 0;

    exp_t q_m[$];
    exp_t q_l[$];
    exp_t q_s[$];

    logic m_full;
    int   e8;
    int   e2;

    encoder8_3_seq #(.PRIORITY_MSB(1), .ERR_W(8)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
        .out_valid(vld_m), .out_ready(out_ready), .out_code(code_m), .out_zero(zero_m),
        .out_multi(multi_m), .err_clr(err_clr), .err_cnt(err_m));

    encoder8_3_seq #(.PRIORITY_MSB(0), .ERR_W(8)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
        .out_valid(vld_l), .out_ready(out_ready), .out_code(code_l), .out_zero(zero_l),
        .out_multi(multi_l), .err_clr(err_clr), .err_cnt(err_l));

    encoder8_3_seq #(.PRIORITY_MSB(1), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .out_valid(vld_s), .out_ready(out_ready), .out_code(code_s), .out_zero(zero_s),
        .out_multi(multi_s), .err_clr(err_clr), .err_cnt(err_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: count set bits, then pick highest or lowest set position.
    function automatic exp_t ref_enc(input logic [7:0] d, input bit msb);
        exp_t e;
        int   n;
        int   pos;
        n   = $countones(d);
        pos = 0;
        if (n > 0) begin
            if (msb) begin
                for (int k = 0; k < 8; k++) if (d[k]) pos = k;
            end else begin
                for (int k = 7; k >= 0; k--) if (d[k]) pos = k;
            end
        end
        e.code  = 3'(pos);
        e.zero  = (n == 0);
        e.multi = (n >= 2);
        return e;
    endfunction

    function automatic logic [7:0] dec3_8(input int c);
        logic [7:0] one;
        one = 8'd1;
        return one << c;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic ordy,
                        input logic clr, input logic r);
        logic acc;
        logic exp_rdy;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
        rst       = r;
        #1;
        exp_rdy = !m_full || ordy;
        chk("in_ready_msb", {31'd0, rdy_m}, {31'd0, exp_rdy});
        chk("in_ready_lsb", {31'd0, rdy_l}, {31'd0, exp_rdy});
        chk("in_ready_sat", {31'd0, rdy_s}, {31'd0, exp_rdy});
        @(posedge clk);
        if (r) begin
            m_full = 1'b0;
            e8 = 0;
            e2 = 0;
            q_m.delete();
            q_l.delete();
            q_s.delete();
        end else begin
            acc = v && (!m_full || ordy);
            if (clr) begin
                e8 = 0;
                e2 = 0;
            end
            if (acc) begin
                q_m.push_back(ref_enc(d, 1'b1));
                q_l.push_back(ref_enc(d, 1'b0));
                q_s.push_back(ref_enc(d, 1'b1));
                if ($countones(d) != 1) begin
                    e8 = sat_inc(e8, 255);
                    e2 = sat_inc(e2, 3);
                end
                m_full = 1'b1;
            end else if (ordy) begin
                m_full = 1'b0;
            end
        end
        #1;
        chk("out_valid_msb", {31'd0, vld_m}, {31'd0, m_full});
        chk("out_valid_lsb", {31'd0, vld_l}, {31'd0, m_full});
        chk("out_valid_sat", {31'd0, vld_s}, {31'd0, m_full});
        chk("err_cnt_msb", {24'd0, err_m}, e8);
        chk("err_cnt_lsb", {24'd0, err_l}, e8);
        chk("err_cnt_sat", {30'd0, err_s}, e2);
    endtask

    task automatic cmp_out(input string name, input exp_t e, input logic [2:0] c,
                           input logic z, input logic m);
        chk({name, "_code"}, {29'd0, c}, {29'd0, e.code});
        chk({name, "_zero"}, {31'd0, z}, {31'd0, e.zero});
        chk({name, "_multi"}, {31'd0, m}, {31'd0, e.multi});
    endtask

    // Monitor: one pop per completed output transfer.
    always @(negedge clk) begin
        if (!rst && vld_m && out_ready) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL sb_msb_underflow: got unexpected output code %0d", code_m);
            end else cmp_out("sb_msb", q_m.pop_front(), code_m, zero_m, multi_m);
        end
        if (!rst && vld_l && out_ready) begin
            checks++;
            if (q_l.size() == 0) begin
                errors++;
                $display("FAIL sb_lsb_underflow: got unexpected output code %0d", code_l);
            end else cmp_out("sb_lsb", q_l.pop_front(), code_l, zero_l, multi_l);
        end
        if (!rst && vld_s && out_ready) begin
            checks++;
            if (q_s.size() == 0) begin
                errors++;
                $display("FAIL sb_sat_underflow: got unexpected output code %0d", code_s);
            end else cmp_out("sb_sat", q_s.pop_front(), code_s, zero_s, multi_s);
        end
    end

    initial begin
        int order[8];
        int tmp;
        int j;
        int pick;
        logic [7:0] d;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0; err_clr = 1'b0;
        m_full = 1'b0; e8 = 0; e2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, vld_m}, 32'd0);
        chk("rst_out_code", {29'd0, code_m}, 32'd0);
        chk("rst_out_zero", {31'd0, zero_m}, 32'd0);
        chk("rst_out_multi", {31'd0, multi_m}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_m}, 32'd0);

        // Sweep one-hot codes back-to-back.
        for (int c = 0; c < 8; c++) step(1'b1, dec3_8(c), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Round trip through a decoder, shuffled order.
        for (int c = 0; c < 8; c++) order[c] = c;
        for (int c = 7; c > 0; c--) begin
            j = $urandom_range(0, c);
            tmp = order[c]; order[c] = order[j]; order[j] = tmp;
        end
        for (int c = 0; c < 8; c++) step(1'b1, dec3_8(order[c]), 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Zero-hot and multi-hot inputs.
        step(1'b1, 8'b0000_0000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'b0010_0100, 1'b1, 1'b0, 1'b0);
        chk("bad_multi_code_msb", {29'd0, code_m}, 32'd5);
        chk("bad_multi_code_lsb", {29'd0, code_l}, 32'd2);
        chk("bad_err_cnt_2", {24'd0, err_m}, 32'd2);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold result 3 while 6 waits upstream.
        step(1'b1, 8'b0000_1000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'b0100_0000, 1'b0, 1'b0, 1'b0);
            chk("bp_hold_code", {29'd0, code_m}, 32'd3);
            chk("bp_hold_ready", {31'd0, rdy_m}, 32'd0);
        end
        step(1'b1, 8'b0100_0000, 1'b1, 1'b0, 1'b0);
        chk("bp_next_code", {29'd0, code_m}, 32'd6);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);

        // Saturation of the 2-bit counter, then clear behaviour.
        for (int k = 0; k < 5; k++) step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("sat_err_cnt_3", {30'd0, err_s}, 32'd3);
        step(1'b1, 8'b1000_0001, 1'b1, 1'b1, 1'b0);
        chk("clr_plus_err_1", {30'd0, err_s}, 32'd1);
        step(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        chk("clr_alone_0", {30'd0, err_s}, 32'd0);

        // Reset while holding a result.
        step(1'b1, 8'b0001_0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'b0010_0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'b0000_0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("midrst_out_valid", {31'd0, vld_m}, 32'd0);
        chk("midrst_err_cnt", {24'd0, err_m}, 32'd0);
        chk("midrst_in_ready", {31'd0, rdy_m}, 32'd1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            pick = $urandom_range(0, 9);
            if (pick < 6)       d = dec3_8($urandom_range(0, 7));
            else if (pick == 6) d = 8'd0;
            else                d = 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, 1'b0);
        end

        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        chk("drain_q_msb", q_m.size(), 32'd0);
        chk("drain_q_lsb", q_l.size(), 32'd0);
        chk("drain_q_sat", q_s.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
